vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_delay_line.sv | 37 +++
 rtl/vga_timing_gen.sv | 117 +++++++++++
 tb/tb_vga_timing_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA raster generator family, plus the raw-stage
// bundle that travels down the sync/valid delay line.
package vga_timing_pkg;

    // 640x480@60, 25.175 MHz pixel clock, negative syncs
    localparam int VGA_HD     = 640;
    localparam int VGA_HF     = 16;
    localparam int VGA_HS     = 96;
    localparam int VGA_HB     = 48;
    localparam int VGA_VD     = 480;
    localparam int VGA_VF     = 10;
    localparam int VGA_VS     = 2;
    localparam int VGA_VB     = 33;
    localparam int VGA_HS_POL = 0;
    localparam int VGA_VS_POL = 0;

    // 800x600@60, 40 MHz pixel clock, positive syncs (1056 x 628 totals)
    localparam int SVGA_HD     = 800;
    localparam int SVGA_HF     = 40;
    localparam int SVGA_HS     = 128;
    localparam int SVGA_HB     = 88;
    localparam int SVGA_VD     = 600;
    localparam int SVGA_VF     = 1;
    localparam int SVGA_VS     = 4;
    localparam int SVGA_VB     = 23;
    localparam int SVGA_HS_POL = 1;
    localparam int SVGA_VS_POL = 1;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } raw_t;

    // True when v lies in [lo, lo+len); done at 32 bits so lo+len cannot overflow the counter width.
    function automatic logic in_window(input logic [31:0] v, input logic [31:0] lo, input logic [31:0] len);
        return (v >= lo) && (v < (lo + len));
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that advances only on shift_en; every stage resets
// to RESET_VAL so the outputs are well-defined before the pipe has filled.
module vga_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift chain: stage 0 takes din, each later stage takes its predecessor.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RESET_VAL;
            end
        end else if (shift_en) begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters, undelayed active
// coordinates for the frame-buffer address, and sync/valid delayed PIPE pixel steps.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int HD     = VGA_HD,
    parameter int HF     = VGA_HF,
    parameter int HS     = VGA_HS,
    parameter int HB     = VGA_HB,
    parameter int VD     = VGA_VD,
    parameter int VF     = VGA_VF,
    parameter int VS     = VGA_VS,
    parameter int VB     = VGA_VB,
    parameter int HS_POL = VGA_HS_POL,
    parameter int VS_POL = VGA_VS_POL,
    parameter int CNT_W  = 10,
    parameter int PIPE   = 1,
    parameter int FC_W   = 8
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync,
    output logic             vsync,
    output logic             valid,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_cnt
);

    localparam int               HT      = HD + HF + HS + HB;
    localparam int               VT      = VD + VF + VS + VB;
    localparam logic [CNT_W-1:0] HT_LAST = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] VT_LAST = CNT_W'(VT - 1);
    localparam logic [CNT_W-1:0] HD_C    = CNT_W'(HD);
    localparam logic [CNT_W-1:0] VD_C    = CNT_W'(VD);
    localparam logic             HS_ACT  = 1'(HS_POL);
    localparam logic             VS_ACT  = 1'(VS_POL);

    logic [CNT_W-1:0] pixel_cnt_r;
    logic [CNT_W-1:0] line_cnt_r;
    logic             line_start_r;
    logic             frame_start_r;
    logic [FC_W-1:0]  frame_cnt_r;
    logic             h_wrap_s;
    logic             f_wrap_s;
    raw_t             raw_s;
    raw_t             dly_s;

    assign h_wrap_s = (pixel_cnt_r == HT_LAST);
    assign f_wrap_s = h_wrap_s && (line_cnt_r == VT_LAST);

    // Raster counters, wrap pulses and completed-frame count; all hold while pix_en is low.
    always_ff @(posedge pclk) begin
        if (reset) begin
            pixel_cnt_r   <= '0;
            line_cnt_r    <= '0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_cnt_r   <= '0;
        end else begin
            line_start_r  <= pix_en && h_wrap_s;
            frame_start_r <= pix_en && f_wrap_s;
            if (pix_en) begin
                if (h_wrap_s) begin
                    pixel_cnt_r <= '0;
                    line_cnt_r  <= (line_cnt_r == VT_LAST) ? '0 : line_cnt_r + CNT_W'(1);
                end else begin
                    pixel_cnt_r <= pixel_cnt_r + CNT_W'(1);
                    line_cnt_r  <= line_cnt_r;
                end
                frame_cnt_r <= f_wrap_s ? frame_cnt_r + FC_W'(1) : frame_cnt_r;
            end else begin
                pixel_cnt_r <= pixel_cnt_r;
                line_cnt_r  <= line_cnt_r;
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Raw-stage decode; vsync window depends on the line count only, so it is whole-line.
    always_comb begin
        raw_s     = '0;
        raw_s.act = (pixel_cnt_r < HD_C) && (line_cnt_r < VD_C);
        raw_s.hs  = in_window(32'(pixel_cnt_r), 32'(HD + HF), 32'(HS));
        raw_s.vs  = in_window(32'(line_cnt_r), 32'(VD + VF), 32'(VS));
        if (raw_s.act) begin
            h_cnt = pixel_cnt_r;
            v_cnt = line_cnt_r;
        end else begin
            h_cnt = '0;
            v_cnt = '0;
        end
    end

    vga_delay_line #(
        .WIDTH    (3),
        .DEPTH    (PIPE),
        .RESET_VAL(3'b000)
    ) u_dly (
        .clk     (pclk),
        .reset   (reset),
        .shift_en(pix_en),
        .din     (raw_s),
        .dout    (dly_s)
    );

    assign valid       = dly_s.act;
    assign hsync       = dly_s.hs ~^ HS_ACT;
    assign vsync       = dly_s.vs ~^ VS_ACT;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Five differently configured generators share pclk/reset/pix_en; an arithmetic
// model (step count since reset) predicts every output each cycle.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int NI = 5;
    localparam int HD_A [NI] = '{8, 8, SVGA_HD, VGA_HD, 2};
    localparam int HF_A [NI] = '{2, 2, SVGA_HF, VGA_HF, 1};
    localparam int HS_A [NI] = '{3, 3, SVGA_HS, VGA_HS, 1};
    localparam int HB_A [NI] = '{2, 2, SVGA_HB, VGA_HB, 1};
    localparam int VD_A [NI] = '{4, 4, SVGA_VD, VGA_VD, 2};
    localparam int VF_A [NI] = '{1, 1, SVGA_VF, VGA_VF, 1};
    localparam int VS_A [NI] = '{2, 2, SVGA_VS, VGA_VS, 1};
    localparam int VB_A [NI] = '{1, 1, SVGA_VB, VGA_VB, 1};
    localparam int HP_A [NI] = '{0, 1, 1, 0, 1};
    localparam int VP_A [NI] = '{0, 0, 1, 0, 1};
    localparam int PP_A [NI] = '{1, 3, 2, 1, 8};

    typedef struct {
        int h;
        int v;
        int hs;
        int vs;
        int va;
        int ls;
        int fs;
        int fc;
    } obs_t;

    logic pclk = 1'b0;
    logic reset;
    logic pix_en;

    logic [10:0] hc0, vc0, hc1, vc1, hc2, vc2, hc4, vc4;
    logic [9:0]  hc3, vc3;
    logic        hs0, vs0, va0, ls0, fs0, hs1, vs1, va1, ls1, fs1;
    logic        hs2, vs2, va2, ls2, fs2, hs3, vs3, va3, ls3, fs3;
    logic        hs4, vs4, va4, ls4, fs4;
    logic [7:0]  fc0, fc1, fc2, fc3, fc4;

    int     total = 0;
    int     bad   = 0;
    longint n     = 0;
    bit     pe    = 1'b0;
    bit     started = 1'b0;

    always #5 pclk = ~pclk;

    vga_timing_gen #(.HD(HD_A[0]), .HF(HF_A[0]), .HS(HS_A[0]), .HB(HB_A[0]), .VD(VD_A[0]), .VF(VF_A[0]),
        .VS(VS_A[0]), .VB(VB_A[0]), .HS_POL(HP_A[0]), .VS_POL(VP_A[0]), .CNT_W(11), .PIPE(PP_A[0]), .FC_W(8))
    u0 (.pclk(pclk), .reset(reset), .pix_en(pix_en), .h_cnt(hc0), .v_cnt(vc0), .hsync(hs0), .vsync(vs0),
        .valid(va0), .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0));

    vga_timing_gen #(.HD(HD_A[1]), .HF(HF_A[1]), .HS(HS_A[1]), .HB(HB_A[1]), .VD(VD_A[1]), .VF(VF_A[1]),
        .VS(VS_A[1]), .VB(VB_A[1]), .HS_POL(HP_A[1]), .VS_POL(VP_A[1]), .CNT_W(11), .PIPE(PP_A[1]), .FC_W(8))
    u1 (.pclk(pclk), .reset(reset), .pix_en(pix_en), .h_cnt(hc1), .v_cnt(vc1), .hsync(hs1), .vsync(vs1),
        .valid(va1), .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1));

    vga_timing_gen #(.HD(HD_A[2]), .HF(HF_A[2]), .HS(HS_A[2]), .HB(HB_A[2]), .VD(VD_A[2]), .VF(VF_A[2]),
        .VS(VS_A[2]), .VB(VB_A[2]), .HS_POL(HP_A[2]), .VS_POL(VP_A[2]), .CNT_W(11), .PIPE(PP_A[2]), .FC_W(8))
    u2 (.pclk(pclk), .reset(reset), .pix_en(pix_en), .h_cnt(hc2), .v_cnt(vc2), .hsync(hs2), .vsync(vs2),
        .valid(va2), .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2));

    vga_timing_gen u3 (.pclk(pclk), .reset(reset), .pix_en(pix_en), .h_cnt(hc3), .v_cnt(vc3), .hsync(hs3),
        .vsync(vs3), .valid(va3), .line_start(ls3), .frame_start(fs3), .frame_cnt(fc3));

    vga_timing_gen #(.HD(HD_A[4]), .HF(HF_A[4]), .HS(HS_A[4]), .HB(HB_A[4]), .VD(VD_A[4]), .VF(VF_A[4]),
        .VS(VS_A[4]), .VB(VB_A[4]), .HS_POL(HP_A[4]), .VS_POL(VP_A[4]), .CNT_W(11), .PIPE(PP_A[4]), .FC_W(8))
    u4 (.pclk(pclk), .reset(reset), .pix_en(pix_en), .h_cnt(hc4), .v_cnt(vc4), .hsync(hs4), .vsync(vs4),
        .valid(va4), .line_start(ls4), .frame_start(fs4), .frame_cnt(fc4));

    // Model state: pixel steps taken since the last reset, and whether the last edge was a step.
    always @(posedge pclk) begin
        if (reset) begin
            n       <= 0;
            pe      <= 1'b0;
            started <= 1'b1;
        end else begin
            pe <= pix_en;
            if (pix_en) n <= n + 1;
        end
    end

    function automatic obs_t obs(input int i);
        obs_t o;
        case (i)
            0:       o = '{int'(hc0), int'(vc0), int'(hs0), int'(vs0), int'(va0), int'(ls0), int'(fs0), int'(fc0)};
            1:       o = '{int'(hc1), int'(vc1), int'(hs1), int'(vs1), int'(va1), int'(ls1), int'(fs1), int'(fc1)};
            2:       o = '{int'(hc2), int'(vc2), int'(hs2), int'(vs2), int'(va2), int'(ls2), int'(fs2), int'(fc2)};
            3:       o = '{int'(hc3), int'(vc3), int'(hs3), int'(vs3), int'(va3), int'(ls3), int'(fs3), int'(fc3)};
            default: o = '{int'(hc4), int'(vc4), int'(hs4), int'(vs4), int'(va4), int'(ls4), int'(fs4), int'(fc4)};
        endcase
        return o;
    endfunction

    // Expected outputs after nn steps: position is nn mod the raster, delayed outputs look PIPE steps back.
    function automatic obs_t model(input int i, input longint nn, input bit pen);
        obs_t   e;
        longint ht = HD_A[i] + HF_A[i] + HS_A[i] + HB_A[i];
        longint vt = VD_A[i] + VF_A[i] + VS_A[i] + VB_A[i];
        longint px = nn % ht;
        longint ln = (nn / ht) % vt;
        longint k, kp, kl;
        bit     a  = (px < HD_A[i]) && (ln < VD_A[i]);
        bit     hr = 1'b0;
        bit     vr = 1'b0;
        e.h  = a ? int'(px) : 0;
        e.v  = a ? int'(ln) : 0;
        e.va = 0;
        if (nn >= PP_A[i]) begin
            k  = nn - PP_A[i];
            kp = k % ht;
            kl = (k / ht) % vt;
            e.va = ((kp < HD_A[i]) && (kl < VD_A[i])) ? 1 : 0;
            hr = (kp >= HD_A[i] + HF_A[i]) && (kp < HD_A[i] + HF_A[i] + HS_A[i]);
            vr = (kl >= VD_A[i] + VF_A[i]) && (kl < VD_A[i] + VF_A[i] + VS_A[i]);
        end
        e.hs = hr ? HP_A[i] : 1 - HP_A[i];
        e.vs = vr ? VP_A[i] : 1 - VP_A[i];
        e.ls = (pen && nn > 0 && (nn % ht) == 0) ? 1 : 0;
        e.fs = (pen && nn > 0 && (nn % (ht * vt)) == 0) ? 1 : 0;
        e.fc = int'((nn / (ht * vt)) % 256);
        return e;
    endfunction

    task automatic chk(input string nm, input int i, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0d want=%0d step=%0d t=%0t", nm, i, got, want, n, $time);
        end
    endtask

    task automatic check_all();
        obs_t o, e;
        if (started) begin
            for (int i = 0; i < NI; i++) begin
                o = obs(i);
                e = model(i, n, pe);
                chk("h_cnt", i, o.h, e.h);
                chk("v_cnt", i, o.v, e.v);
                chk("hsync", i, o.hs, e.hs);
                chk("vsync", i, o.vs, e.vs);
                chk("valid", i, o.va, e.va);
                chk("line_start", i, o.ls, e.ls);
                chk("frame_start", i, o.fs, e.fs);
                chk("frame_cnt", i, o.fc, e.fc);
            end
        end
    endtask

    initial begin
        int  cnt_va, cnt_hl, cnt_ls, cnt_h2, cnt_vl, cnt_ls0, cnt_ls3, dbl;
        int  prev_fc4, prev_ls0;
        bit  wrap4, found;
        cnt_va = 0; cnt_hl = 0; cnt_ls = 0; cnt_h2 = 0; cnt_vl = 0;
        cnt_ls0 = 0; cnt_ls3 = 0; dbl = 0; prev_fc4 = 0; prev_ls0 = 0;
        wrap4 = 1'b0; found = 1'b0;

        reset  = 1'b1;
        pix_en = 1'b0;
        repeat (3) @(negedge pclk);
        check_all();
        chk("rst_hsync_lowpol", 3, obs(3).hs, 1);
        chk("rst_vsync_lowpol", 3, obs(3).vs, 1);
        chk("rst_hsync_highpol", 2, obs(2).hs, 0);
        chk("rst_valid", 3, obs(3).va, 0);

        // reset and pix_en together: reset wins
        pix_en = 1'b1;
        repeat (2) @(negedge pclk);
        check_all();
        chk("rst_win_h", 0, obs(0).h, 0);
        chk("rst_win_fc", 0, obs(0).fc, 0);

        // continuous pixel stream; after iteration c exactly c+1 steps have been taken
        reset = 1'b0;
        for (int c = 0; c < 9000; c++) begin
            @(negedge pclk);
            check_all();
            if (c == 0) chk("pipe1_valid_rise", 0, obs(0).va, 1);
            if (c == 1) chk("pipe3_valid_pre", 1, obs(1).va, 0);
            if (c == 2) chk("pipe3_valid_rise", 1, obs(1).va, 1);
            if (c == 9) chk("pipe3_valid_last", 1, obs(1).va, 1);
            if (c == 10) chk("pipe3_valid_fall", 1, obs(1).va, 0);
            if (c == 238) chk("fc_one", 0, obs(0).fc, 1);
            if (c == 239) begin
                chk("fc_two", 0, obs(0).fc, 2);
                chk("fs_pulse", 0, obs(0).fs, 1);
            end
            if (c == 840) chk("svga_hs_pre", 2, obs(2).hs, 0);
            if (c == 841) chk("svga_hs_start", 2, obs(2).hs, 1);
            if (c >= 1000 && c < 1800) begin
                cnt_va += obs(3).va;
                cnt_hl += 1 - obs(3).hs;
                cnt_ls += obs(3).ls;
            end
            if (c >= 2000 && c < 3056) cnt_h2 += obs(2).hs;
            if (c >= 500 && c < 620) cnt_vl += 1 - obs(0).vs;
            if (prev_fc4 == 255 && obs(4).fc == 0) wrap4 = 1'b1;
            prev_fc4 = obs(4).fc;
        end
        chk("vga_valid_per_line", 3, cnt_va, 640);
        chk("vga_hsync_low_per_line", 3, cnt_hl, 96);
        chk("vga_line_starts_per_800", 3, cnt_ls, 1);
        chk("svga_hsync_high_per_line", 2, cnt_h2, 128);
        chk("vsync_low_per_frame", 0, cnt_vl, 30);
        chk("fc_mod256", 4, obs(4).fc, 104);
        chk("fc_wrap_seen", 4, int'(wrap4), 1);

        // pix_en every other pclk: periods double, pulses stay one pclk wide
        for (int c = 0; c < 2000; c++) begin
            @(negedge pclk);
            check_all();
            if (c >= 100 && c < 400) cnt_ls0 += obs(0).ls;
            if (c >= 200 && c < 1800) cnt_ls3 += obs(3).ls;
            if (prev_ls0 == 1 && obs(0).ls == 1) dbl++;
            prev_ls0 = obs(0).ls;
            pix_en = ~pix_en;
        end
        chk("half_rate_ls_per_300", 0, cnt_ls0, 10);
        chk("half_rate_ls_per_1600", 3, cnt_ls3, 1);
        chk("ls_never_stretches", 0, dbl, 0);

        // mid-frame reset at pixel 5, line 2 of the small raster
        pix_en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge pclk);
            check_all();
            if ((n % 120) == 35) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_target_reached", 0, int'(found), 1);
        chk("mid_pre_h", 0, obs(0).h, 5);
        chk("mid_pre_v", 0, obs(0).v, 2);
        reset = 1'b1;
        @(negedge pclk);
        check_all();
        chk("mid_rst_valid", 0, obs(0).va, 0);
        chk("mid_rst_hsync", 0, obs(0).hs, 1);
        chk("mid_rst_vsync", 0, obs(0).vs, 1);
        chk("mid_rst_fs", 0, obs(0).fs, 0);
        chk("mid_rst_fc", 0, obs(0).fc, 0);
        chk("mid_rst_h", 0, obs(0).h, 0);
        reset = 1'b0;
        repeat (300) begin
            @(negedge pclk);
            check_all();
        end

        // random pixel strobes with occasional resets
        for (int c = 0; c < 6000; c++) begin
            pix_en = ($urandom % 4) != 0;
            reset  = ($urandom % 400) == 0;
            @(negedge pclk);
            check_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
